// File: rtl/bht_flush_walk_pkg.sv
// Shared frontend types for the branch history table.
// Entry, prediction and update bundles plus the clear-walk FSM states.
package bht_flush_walk_pkg;

  localparam int VLEN = 32;

  typedef struct packed {
    logic            valid;
    logic [VLEN-1:0] pc;
    logic            taken;
  } bht_update_t;

  typedef struct packed {
    logic valid;
    logic taken;
  } bht_prediction_t;

  typedef struct packed {
    logic       valid;
    logic [1:0] ctr;
  } bht_entry_t;

  typedef enum logic {
    S_IDLE,
    S_CLEAR
  } bht_state_t;

endpackage

// File: rtl/bht_flush_walk.sv
// 2-bit saturating-counter BHT with a row-by-row flush walker.
// Lookup is combinational; updates and clears land on the clock edge.
module bht_flush_walk #(
  parameter int NR_ENTRIES      = 128,
  parameter int VLEN            = 32,
  parameter int INSTR_PER_FETCH = 2
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic                       flush_i,
  input  logic                       debug_mode_i,
  input  logic [VLEN-1:0]            vpc_i,
  input  logic                       bht_update_valid_i,
  input  logic [VLEN-1:0]            bht_update_pc_i,
  input  logic                       bht_update_taken_i,
  output logic [INSTR_PER_FETCH-1:0] bht_pred_valid_o,
  output logic [INSTR_PER_FETCH-1:0] bht_pred_taken_o,
  output logic                       busy_o
);
  import bht_flush_walk_pkg::*;

  localparam int NR_ROWS       = NR_ENTRIES / INSTR_PER_FETCH;
  localparam int ROW_ADDR_BITS = $clog2(INSTR_PER_FETCH);
  localparam int OFFSET        = 1;
  localparam int INDEX_BITS    = $clog2(NR_ROWS);

  localparam logic [INDEX_BITS-1:0] LAST_ROW =
    INDEX_BITS'(NR_ROWS - 1);

  function automatic logic [INDEX_BITS-1:0] row_of(
    input logic [VLEN-1:0] pc
  );
    return pc[OFFSET+ROW_ADDR_BITS +: INDEX_BITS];
  endfunction

  function automatic logic [ROW_ADDR_BITS-1:0] col_of(
    input logic [VLEN-1:0] pc
  );
    return pc[OFFSET +: ROW_ADDR_BITS];
  endfunction

  function automatic bht_entry_t sat_update(
    input bht_entry_t e,
    input logic       taken
  );
    bht_entry_t n;
    n.valid = 1'b1;
    if (!e.valid)
      n.ctr = taken ? 2'b10 : 2'b01;
    else if (taken)
      n.ctr = (e.ctr == 2'b11) ? e.ctr : e.ctr + 2'b01;
    else
      n.ctr = (e.ctr == 2'b00) ? e.ctr : e.ctr - 2'b01;
    return n;
  endfunction

  bht_entry_t bht_q [NR_ROWS][INSTR_PER_FETCH];
  bht_state_t state_q;
  logic [INDEX_BITS-1:0] clr_idx_q;
  logic busy_q;

  bht_update_t upd;
  logic [INDEX_BITS-1:0]    upd_row;
  logic [ROW_ADDR_BITS-1:0] upd_col;
  logic [INDEX_BITS-1:0]    lkp_row;
  logic [INDEX_BITS-1:0]    clr_row;
  bht_prediction_t pred [INSTR_PER_FETCH];
  logic unused_pc_bits;

  assign upd.valid = bht_update_valid_i;
  assign upd.pc    = bht_update_pc_i;
  assign upd.taken = bht_update_taken_i;

  assign upd_row = row_of(upd.pc);
  assign upd_col = col_of(upd.pc);
  assign lkp_row = row_of(vpc_i);

  // A re-flush mid-walk clears row 0 in the same cycle.
  assign clr_row = flush_i ? '0 : clr_idx_q;

  assign unused_pc_bits = ^{vpc_i, upd.pc};

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int r = 0; r < NR_ROWS; r++)
        for (int c = 0; c < INSTR_PER_FETCH; c++)
          bht_q[r][c] <= '0;
      state_q   <= S_IDLE;
      clr_idx_q <= '0;
      busy_q    <= 1'b0;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          if (flush_i) begin
            state_q   <= S_CLEAR;
            clr_idx_q <= '0;
            busy_q    <= 1'b1;
          end else if (upd.valid && !debug_mode_i) begin
            bht_q[upd_row][upd_col] <=
              sat_update(bht_q[upd_row][upd_col], upd.taken);
          end
        end
        S_CLEAR: begin
          for (int c = 0; c < INSTR_PER_FETCH; c++)
            bht_q[clr_row][c] <= '0;
          if (flush_i) begin
            clr_idx_q <= INDEX_BITS'(1);
          end else if (clr_idx_q == LAST_ROW) begin
            state_q <= S_IDLE;
            busy_q  <= 1'b0;
          end else begin
            clr_idx_q <= clr_idx_q + INDEX_BITS'(1);
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  always_comb begin
    for (int c = 0; c < INSTR_PER_FETCH; c++) begin
      pred[c].valid = !busy_q && bht_q[lkp_row][c].valid;
      pred[c].taken = !busy_q && bht_q[lkp_row][c].ctr[1];
    end
  end

  always_comb begin
    bht_pred_valid_o = '0;
    bht_pred_taken_o = '0;
    for (int c = 0; c < INSTR_PER_FETCH; c++) begin
      bht_pred_valid_o[c] = pred[c].valid;
      bht_pred_taken_o[c] = pred[c].taken;
    end
  end

  assign busy_o = busy_q;

endmodule
